// File: rtl/lane_write_arbiter.sv
// Lane register bank owner: loads the alternating lane pattern one slice per
// cycle after reset or clr, then grants masked writes round-robin.
module lane_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int INIT_STEP = 8
) (
  input  logic                   c,
  input  logic                   r,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic [N_REQ*WIDTH-1:0] wmask,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   init_done,
  output logic [WIDTH-1:0]       a
);

  localparam int N_SLICE = WIDTH / INIT_STEP;
  localparam int SPW     = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam int PPW     = $clog2(N_REQ);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [PPW-1:0]   pp_q, pp_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d;

  logic [WIDTH-1:0] in_slice;
  logic [WIDTH-1:0] init_pat;
  logic [WIDTH-1:0] wdata_arr [N_REQ];
  logic [WIDTH-1:0] wmask_arr [N_REQ];
  logic             last_slice;
  logic             found;
  logic [PPW-1:0]   win;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign in_slice[gi] = (sp_q == SPW'(gi / INIT_STEP));
      assign init_pat[gi] = ((gi % 2) == 1);
    end
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
      assign wmask_arr[gi] = wmask[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign last_slice = (sp_q == SPW'(N_SLICE - 1));

  // Scan downward so the last hit is the first set bit at or above pp.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(pp_q) + k) % N_REQ;
      if (req[idx]) begin
        found = 1'b1;
        win   = PPW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state_q <= S_INIT;
      sp_q    <= '0;
      pp_q    <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      pp_q    <= pp_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (last_slice) state_d = S_RUN;
      S_RUN:   if (clr)        state_d = S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  // Datapath next values; clr outranks any request on the same edge.
  always_comb begin
    a_d   = a_q;
    sp_d  = sp_q;
    pp_d  = pp_q;
    gnt_d = '0;
    if (state_q == S_INIT) begin
      a_d  = (a_q & ~in_slice) | (init_pat & in_slice);
      sp_d = last_slice ? '0 : sp_q + SPW'(1);
    end else if (clr) begin
      sp_d = '0;
    end else if (found) begin
      a_d        = (a_q & ~wmask_arr[win]) | (wdata_arr[win] & wmask_arr[win]);
      gnt_d[win] = 1'b1;
      pp_d       = (win == PPW'(N_REQ - 1)) ? '0 : win + PPW'(1);
    end
  end

  // Output decode.
  always_comb begin
    busy      = (state_q == S_INIT);
    init_done = (state_q == S_RUN);
    gnt       = gnt_q;
    a         = a_q;
  end

endmodule

// File: doc/lane_write_arbiter.md
# lane_write_arbiter

Controller that owns a 32-bit lane register bank and shares write access to it among several requesters. After reset it runs an initialisation sequence that loads the alternating per-lane default pattern: lane j gets j%2. The load covers one slice per cycle. It then grants masked writes round-robin, one requester per cycle. It sits between the lane-control clients and the lane register outputs that drive the datapath.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, lane register width
- INIT_STEP, 8, lanes loaded per init cycle; must divide WIDTH

Ports:
- c  input  1  clock, all state on rising edge
- r  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous re-initialisation request
- req  input  N_REQ  write request, one bit per requester
- wdata  input  N_REQ*WIDTH  write data, requester k at [k*WIDTH +: WIDTH]
- wmask  input  N_REQ*WIDTH  per-lane write enable, same packing as wdata
- gnt  output  N_REQ  one-hot grant pulse, registered
- busy  output  1  high while in INIT
- init_done  output  1  high while in RUN
- a  output  WIDTH  lane register bank

## Operation
- Reset (r=0, asynchronous) forces the following immediately, independent of c:
  - a=0, gnt=0, busy=1, init_done=0
  - state=INIT, slice pointer sp=0, priority pointer pp=0
- The FSM has two states: INIT and RUN.
- INIT, per edge:
  - a[sp*INIT_STEP +: INIT_STEP] loads lane pattern j%2, so odd lanes load 1 and even lanes load 0.
  - Other lanes are unchanged.
  - sp increments.
  - On the edge with sp==WIDTH/INIT_STEP-1, the last slice is written and state becomes RUN; sp returns to 0.
  - req is ignored and gnt stays 0.
- RUN, per edge:
  - If clr=1: state becomes INIT, sp=0, no grant, a is held. clr has priority over any req on the same edge.
  - Else if any req bit is set, the winner w is the first set bit searching from pp upward, wrapping modulo N_REQ.
    - For each lane i, a[i] <= wmask[w*WIDTH+i] ? wdata[w*WIDTH+i] : a[i].
    - gnt <= one-hot(w).
    - pp <= (w+1) mod N_REQ.
  - Else gnt <= 0 and a is held.
- clr is ignored in INIT; the sequence is not restarted.
- Requester protocol:
  - Hold req and its data stable until gnt is seen.
  - The write is already committed on the edge that raises gnt.
  - If req is still high in the gnt cycle, it counts as a new request. Under contention it ranks last, because pp has moved past it.
- An all-zero wmask is a legal grant: gnt pulses and a is unchanged.
- busy = (state==INIT) and init_done = (state==RUN), both decoded directly from the state register.

## Timing
- Init latency is WIDTH/INIT_STEP edges after r deasserts. With defaults, init_done rises after edge 4 and a=0xAAAAAAAA.
- Write latency is one edge: req sampled at edge n gives the new a value and gnt high after edge n.
- gnt is high for exactly one cycle per grant. A sole continuous requester is granted every cycle.
- Throughput is one write per cycle. Worst-case wait for a requester holding req is N_REQ-1 grants to others.
- r asserted mid-write: the pending write is dropped and a returns to 0 asynchronously. Initialisation then restarts from sp=0.
- Every bit of a is driven only by r, the init slice write or the granted write.

## Test plan
- Reset then release, no req → a is 0x000000AA, 0x0000AAAA, 0x00AAAAAA, 0xAAAAAAAA after edges 1-4; busy=1 through edge 3; init_done=1 after edge 4.
- In RUN, req=0001, wdata0=0x12345678, wmask0=0xFFFF0000 → after one edge a=0x1234AAAA, gnt=0001 for one cycle, pp=1.
- All four req held continuously from pp=0 → gnt sequence 0001, 0010, 0100, 1000, 0001, …, one grant per cycle.
- clr=1 and req=0010 on the same edge in RUN → gnt stays 0, a unchanged, busy=1, four init edges restore 0xAAAAAAAA, then req=0010 is granted.
- r pulsed low mid-INIT after edge 2 and also mid-RUN → a=0, gnt=0, busy=1 immediately with no clock edge; full init reruns after release.
- req=0100 with wmask=0 → gnt=0100 pulses, a unchanged, pp=3.
